// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable counter serial loader.
// PROG_LOADER_PARITY_EN adds a trailing even-parity bit to every frame.
package prog_counter_pkg;

  localparam logic [7:0] CMD_LOAD      = 8'h01;
  localparam logic [7:0] CMD_SET_EN    = 8'h02;
  localparam logic [7:0] CMD_SET_DRIVE = 8'h03;

`ifdef PROG_LOADER_PARITY_EN
  localparam int unsigned FRAME_BITS = 17;
`else
  localparam int unsigned FRAME_BITS = 16;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, EXEC} state_e;

  function automatic logic cmd_valid(input logic [7:0] cmd);
    return (cmd == CMD_LOAD) || (cmd == CMD_SET_EN) || (cmd == CMD_SET_DRIVE);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with registered rise/fall detection on the synchronised level.
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      last_q <= IDLE_LEVEL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      last_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/prog_counter_serial_loader.sv
// Serial command front end for the programmable counter: resynchronises a cs/clk/dat frame
// and drives load/enable/drive controls. PROG_LOADER_PARITY_EN selects 17-bit parity frames.
module prog_counter_serial_loader
  import prog_counter_pkg::*;
#(
  parameter logic        DEFAULT_EN    = 1'b1,
  parameter logic        DEFAULT_DRIVE = 1'b1,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       ser_cs_n_i,
  input  logic       ser_clk_i,
  input  logic       ser_dat_i,
  output logic [7:0] load_val_o,
  output logic       load_o,
  output logic       en_o,
  output logic       oe_o,
  output logic       busy_o,
  output logic       frame_err_o
);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic dat_lvl, dat_rise, dat_fall;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(ser_cs_n_i),
    .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .d_i(ser_clk_i),
    .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_dat (
    .clk(clk), .rst_n(rst_n), .d_i(ser_dat_i),
    .level_o(dat_lvl), .rise_o(dat_rise), .fall_o(dat_fall)
  );

  assign unused_edges = ^{cs_fall, sclk_lvl, sclk_fall, dat_rise, dat_fall};

  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d, sr_shift;
  logic [4:0]            cnt_q, cnt_d, cnt_shift;
  logic [7:0]            load_val_q, load_val_d;
  logic                  load_q, load_d;
  logic                  en_q, en_d;
  logic                  oe_q, oe_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic [15:0]           payload;
  logic                  frame_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      load_val_q <= 8'h00;
      load_q     <= 1'b0;
      en_q       <= DEFAULT_EN;
      oe_q       <= DEFAULT_DRIVE;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      load_val_q <= load_val_d;
      load_q     <= load_d;
      en_q       <= en_d;
      oe_q       <= oe_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Frame as it stands after this cycle's shift, so a bit landing with the cs_n rise counts.
  always_comb begin
    sr_shift  = sclk_rise ? {sr_q[FRAME_BITS-2:0], dat_lvl} : sr_q;
    cnt_shift = (sclk_rise && (cnt_q != 5'd31)) ? cnt_q + 5'd1 : cnt_q;
    payload   = sr_shift[FRAME_BITS-1 -: 16];
    frame_ok  = (cnt_shift == 5'(FRAME_BITS)) && cmd_valid(payload[15:8]);
`ifdef PROG_LOADER_PARITY_EN
    frame_ok  = frame_ok && !(^sr_shift);
`endif
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    load_val_d = load_val_q;
    load_d     = 1'b0;
    en_d       = en_q;
    oe_d       = oe_q;
    err_d      = err_q;

    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!cs_lvl) begin
            state_d = SHIFT;
            sr_d    = '0;
            cnt_d   = '0;
          end
        end
        SHIFT: begin
          sr_d  = sr_shift;
          cnt_d = cnt_shift;
          if (cs_rise) begin
            state_d = EXEC;
            if (frame_ok) begin
              err_d = 1'b0;
              case (payload[15:8])
                CMD_LOAD: begin
                  load_val_d = payload[7:0];
                  load_d     = 1'b1;
                end
                CMD_SET_EN: en_d = payload[0];
                default:    oe_d = payload[0];
              endcase
            end else begin
              err_d = 1'b1;
            end
          end
        end
        EXEC:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign load_val_o  = load_val_q;
  assign load_o      = load_q;
  assign en_o        = en_q;
  assign oe_o        = oe_q;
  assign busy_o      = busy_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_prog_counter_serial_loader.sv
// Directed plus randomized frame bench for prog_counter_serial_loader with a frame-level model.
module tb_prog_counter_serial_loader;
  import prog_counter_pkg::*;

  localparam int unsigned SS = 2;
  localparam int unsigned FB = FRAME_BITS;

  logic       clk = 1'b0;
  logic       rst_n, ena, cs_n, sclk, sdat;
  logic [7:0] load_val_o;
  logic       load_o, en_o, oe_o, busy_o, frame_err_o;

  always #5 clk = ~clk;

  prog_counter_serial_loader #(
    .DEFAULT_EN(1'b1), .DEFAULT_DRIVE(1'b0), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ser_cs_n_i(cs_n), .ser_clk_i(sclk), .ser_dat_i(sdat),
    .load_val_o(load_val_o), .load_o(load_o), .en_o(en_o), .oe_o(oe_o),
    .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  int checks = 0;
  int errors = 0;

  // Expected counter controls after the frames seen so far
  logic [7:0] m_val;
  logic       m_en, m_oe, m_err;
  int         pulse_cnt, pulse_pos;
  logic       busy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] make_frame(input logic [7:0] cmd, input logic [7:0] data);
`ifdef PROG_LOADER_PARITY_EN
    return {15'd0, cmd, data, ^{cmd, data}};
`else
    return {16'd0, cmd, data};
`endif
  endfunction

  function automatic logic model(input logic [31:0] bits, input int n);
    logic [15:0] pl;
    logic        ok;
    pl = 16'(bits >> (FB - 16));
    ok = (n == int'(FB)) && (pl[15:8] == 8'h01 || pl[15:8] == 8'h02 || pl[15:8] == 8'h03);
`ifdef PROG_LOADER_PARITY_EN
    ok = ok && (^bits[16:0] == 1'b0);
`endif
    if (!ok) begin
      m_err = 1'b1;
      return 1'b0;
    end
    m_err = 1'b0;
    if (pl[15:8] == 8'h01) m_val = pl[7:0];
    else if (pl[15:8] == 8'h02) m_en = pl[0];
    else m_oe = pl[0];
    return pl[15:8] == 8'h01;
  endfunction

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdat = bits[i];
      clocks(4);
      sclk = 1'b1;
      clocks(4);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    @(negedge clk);
    cs_n = 1'b0;
    clocks(4);
    shift_bits(bits, n);
    busy_seen = busy_o;
    clocks(4);
    cs_n = 1'b1;
    pulse_cnt = 0;
    pulse_pos = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (load_o) begin
        pulse_cnt++;
        if (pulse_pos == 0) pulse_pos = k;
      end
    end
    clocks(2);
  endtask

  task automatic frame_and_check(input string tag, input logic [31:0] bits, input int n);
    logic exp_load;
    send_frame(bits, n);
    exp_load = model(bits, n);
    chk({tag, ".busy"}, 32'(busy_seen), 32'd1);
    chk({tag, ".val"}, 32'(load_val_o), 32'(m_val));
    chk({tag, ".en"}, 32'(en_o), 32'(m_en));
    chk({tag, ".oe"}, 32'(oe_o), 32'(m_oe));
    chk({tag, ".err"}, 32'(frame_err_o), 32'(m_err));
    chk({tag, ".pulses"}, 32'(pulse_cnt), exp_load ? 32'd1 : 32'd0);
    if (exp_load) chk({tag, ".pulse_pos"}, 32'(pulse_pos), 32'(SS + 2));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".val"}, 32'(load_val_o), 32'h00);
    chk({tag, ".load"}, 32'(load_o), 32'd0);
    chk({tag, ".en"}, 32'(en_o), 32'd1);
    chk({tag, ".oe"}, 32'(oe_o), 32'd0);
    chk({tag, ".busy"}, 32'(busy_o), 32'd0);
    chk({tag, ".err"}, 32'(frame_err_o), 32'd0);
  endtask

  initial begin
    logic [31:0] bits;
    logic [7:0]  cmd;
    int          r, n;

    rst_n = 1'b0; ena = 1'b1; cs_n = 1'b1; sclk = 1'b0; sdat = 1'b0;
    m_val = 8'h00; m_en = 1'b1; m_oe = 1'b0; m_err = 1'b0;
    clocks(3);
    check_reset_values("in_reset");
    rst_n = 1'b1;
    clocks(3);
    check_reset_values("after_reset");

    frame_and_check("load_a5", make_frame(8'h01, 8'hA5), FB);
    frame_and_check("set_en0", make_frame(8'h02, 8'h00), FB);
    frame_and_check("set_drv1", make_frame(8'h03, 8'h01), FB);

    bits = make_frame(8'h01, 8'h3C);
    frame_and_check("short", bits >> 1, FB - 1);
    frame_and_check("long", {bits[30:0], 1'b1}, FB + 1);
    frame_and_check("bad_cmd", make_frame(8'h7F, 8'h00), FB);
    frame_and_check("load_42", make_frame(8'h01, 8'h42), FB);

`ifdef PROG_LOADER_PARITY_EN
    bits = make_frame(8'h01, 8'hA5);
    frame_and_check("par_good", bits, FB);
    frame_and_check("load_11", make_frame(8'h01, 8'h11), FB);
    frame_and_check("par_bad", bits ^ 32'd1, FB);
`endif

    // ena dropped mid-frame: partial frame discarded, no error, outputs hold
    frame_and_check("pre_abort", make_frame(8'h01, 8'h99), FB);
    @(negedge clk);
    cs_n = 1'b0;
    clocks(4);
    bits = make_frame(8'h01, 8'h77);
    shift_bits(bits >> (FB - 8), 8);
    ena = 1'b0;
    clocks(2);
    chk("abort.busy", 32'(busy_o), 32'd0);
    cs_n = 1'b1;
    clocks(6);
    ena = 1'b1;
    clocks(2);
    chk("abort.err", 32'(frame_err_o), 32'(m_err));
    chk("abort.val", 32'(load_val_o), 32'(m_val));
    frame_and_check("load_55", make_frame(8'h01, 8'h55), FB);

    for (int i = 0; i < 24; i++) begin
      r   = int'($urandom_range(0, 5));
      cmd = (r < 3) ? 8'(r + 1) : 8'($urandom);
      bits = make_frame(cmd, 8'($urandom));
      n = int'(FB);
      if (r == 4) begin
        bits = {bits[30:0], 1'($urandom)};
        n = int'(FB) + 1;
      end else if (r == 5) begin
        bits = bits >> 1;
        n = int'(FB) - 1;
      end
      frame_and_check("rand", bits, n);
    end

    // Async reset mid-frame after leaving state away from reset values
    frame_and_check("pre_rst_en", make_frame(8'h02, 8'h00), FB);
    frame_and_check("pre_rst_oe", make_frame(8'h03, 8'h01), FB);
    frame_and_check("pre_rst_err", make_frame(8'h44, 8'h00), FB);
    @(negedge clk);
    cs_n = 1'b0;
    clocks(4);
    shift_bits(32'h0000_02AA, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    cs_n = 1'b1;
    clocks(2);
    rst_n = 1'b1;
    m_val = 8'h00; m_en = 1'b1; m_oe = 1'b0; m_err = 1'b0;
    clocks(6);
    frame_and_check("post_rst", make_frame(8'h01, 8'hC3), FB);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
